imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
Shares the single combinational read port of the instruction ROM between two requesters. Port 0 is the pipeline fetch stage. Port 1 is the data-side/debug read path, used for constant loads from the ROM region. Each port has a valid/ready request handshake and a one-entry registered response buffer with its own valid/ready handshake. Arbitration is round-robin, and range and alignment faults are checked on every granted request.

Parameters:
A_WIDTH, 32, address width of requests and of the ROM port
BASE, 32'hBFC00000, first byte address mapped to the ROM
SIZE, 32'h1000, ROM size in bytes; must be a multiple of 4
ALIGN_CHECK, 1, when 1, a request with addr[1:0]!=0 faults

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  fetch request valid
req0_ready  out  1  fetch request accepted this cycle
req0_addr  in  A_WIDTH  fetch byte address
rsp0_valid  out  1  fetch response buffer full
rsp0_ready  in  1  fetch consumer takes the response
rsp0_data  out  32  fetched word, little-endian as assembled by the ROM
rsp0_fault  out  1  response is a faulted access
req1_valid, req1_ready, req1_addr, rsp1_valid, rsp1_ready, rsp1_data, rsp1_fault  same as port 0, for requester 1
rom_addr  out  A_WIDTH  address driven to the ROM
rom_dout  in  32  combinational ROM read data

Behaviour:
- Reset (rst=1 at a clock edge): rsp0_valid=rsp1_valid=0, rsp*_data=0, rsp*_fault=0, round-robin pointer last_grant=1, so port 0 wins the first tie. Any request in flight is dropped with no response. Outputs hold these values until the first grant.
- Slot free: port n's slot is free when rspn_valid=0, or when rspn_valid=1 and rspn_ready=1 in the same cycle (drain and refill allowed).
- Eligibility: port n is eligible when reqn_valid=1 and its slot is free.
- Grant rule: at most one grant per cycle. If only one port is eligible, it wins. If both are eligible, the port other than last_grant wins. last_grant updates only on a grant.
- Ready signals: reqn_ready=1 exactly when port n is granted. They are combinational from reqn_valid, rspn_ready and state.
- ROM address: rom_addr = granted port's address. When no port is granted, rom_addr = BASE.
- Fault check, combinational on the granted address:
  - fault if addr < BASE;
  - fault if addr > BASE+SIZE-4 (unsigned, computed in A_WIDTH+1 bits so there is no wrap);
  - fault if ALIGN_CHECK=1 and addr[1:0]!=0.
- Capture (cycle after grant, latency 1): rspn_valid=1, rspn_fault=fault, rspn_data = fault ? 0 : rom_dout.
- Drain: when rspn_valid=1, rspn_ready=1 and there is no new grant for port n, rspn_valid becomes 0. Data and fault hold their last values.
- Hold: while rspn_valid=1 and rspn_ready=0, rspn_data and rspn_fault are stable and port n is not granted.
- Independence: a stalled port does not block the other. The other port may be granted every cycle.
- Throughput: one access per cycle in aggregate. A single port with rspn_ready held high sustains one response per cycle.
- Request hold: requesters hold reqn_addr stable while reqn_valid=1 and reqn_ready=0. The block does not latch unaccepted requests.
- Reset mid-operation: reset overrides all grants and drains in that cycle.

Test Plan:
- Reset: assert rst 2 cycles with both requests valid -> rsp0_valid=rsp1_valid=0, rsp*_data=0, no req*_ready while rst=1.
- Single fetch: req0 addr 32'hBFC00004, ROM word 32'h00500093, rsp0_ready=1 -> req0_ready=1 in cycle T, rsp0_valid=1 with data 32'h00500093 and fault=0 in T+1. A streaming fetch of 4 consecutive addresses gives 4 back-to-back responses.
- Contention: both ports valid continuously, both ready -> grants alternate 0,1,0,1 starting with port 0 after reset. Each port gets 50% of grants over 8 cycles.
- Back-pressure: rsp1_ready=0 with rsp1_valid=1, both requesting -> port 1 is never granted and rsp1_data is stable. Port 0 is granted every cycle. Raising rsp1_ready gives port 1 a drain-and-refill in the same cycle.
- Faults: addresses 32'hBFBFFFFC, 32'hBFC01000 and 32'hBFC00002 each give rsp_fault=1 and data=0. Address 32'hBFC00FFC gives fault=0 with valid data.
- Reset mid-operation: assert rst in the cycle after a grant -> no response is delivered, and port 0 wins the next tie.

Source files
------------

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the combinational instruction-ROM read port between
// the fetch stage (port 0) and the data/debug read path (port 1).
module imem_arbiter #(
    parameter int unsigned          A_WIDTH     = 32,
    parameter logic [A_WIDTH-1:0]   BASE        = 32'hBFC00000,
    parameter logic [A_WIDTH-1:0]   SIZE        = 32'h1000,
    parameter bit                   ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [A_WIDTH-1:0] req0_addr,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [31:0]        rsp0_data,
    output logic               rsp0_fault,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [A_WIDTH-1:0] req1_addr,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [31:0]        rsp1_data,
    output logic               rsp1_fault,
    output logic [A_WIDTH-1:0] rom_addr,
    input  logic [31:0]        rom_dout
);

    // Last legal word address, one bit wider so BASE+SIZE cannot wrap.
    localparam logic [A_WIDTH:0] LAST_WORD =
        {1'b0, BASE} + {1'b0, SIZE} - (A_WIDTH+1)'(4);

    logic        rsp0_valid_q, rsp1_valid_q;
    logic [31:0] rsp0_data_q, rsp1_data_q;
    logic        rsp0_fault_q, rsp1_fault_q;
    logic        last_grant_q;

    logic free0, free1, elig0, elig1, gnt0, gnt1;
    logic fault;

    // Handshake: a request transfers on a cycle where valid and ready are both high;
    // a response transfers when rsp valid and ready are both high. A slot that is
    // draining this cycle may be refilled in the same cycle.
    always_comb begin
        free0 = !rsp0_valid_q || rsp0_ready;
        free1 = !rsp1_valid_q || rsp1_ready;
        elig0 = req0_valid && free0;
        elig1 = req1_valid && free1;
        gnt0  = !rst && elig0 && (!elig1 || last_grant_q);
        gnt1  = !rst && elig1 && (!elig0 || !last_grant_q);
    end

    always_comb begin
        rom_addr = BASE;
        if (gnt0) begin
            rom_addr = req0_addr;
        end else if (gnt1) begin
            rom_addr = req1_addr;
        end
        fault = (rom_addr < BASE) || ({1'b0, rom_addr} > LAST_WORD) ||
                (ALIGN_CHECK && (rom_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_fault_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_fault_q <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            if (gnt0) begin
                rsp0_valid_q <= 1'b1;
                rsp0_fault_q <= fault;
                rsp0_data_q  <= fault ? 32'h0 : rom_dout;
                last_grant_q <= 1'b0;
            end else if (rsp0_valid_q && rsp0_ready) begin
                rsp0_valid_q <= 1'b0;
            end
            if (gnt1) begin
                rsp1_valid_q <= 1'b1;
                rsp1_fault_q <= fault;
                rsp1_data_q  <= fault ? 32'h0 : rom_dout;
                last_grant_q <= 1'b1;
            end else if (rsp1_valid_q && rsp1_ready) begin
                rsp1_valid_q <= 1'b0;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_fault = rsp0_fault_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_fault = rsp1_fault_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small combinational ROM model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_fault;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_fault;
    logic [31:0] req0_addr, req1_addr, rsp0_data, rsp1_data, rom_addr, rom_dout;

    int pass_cnt = 0;
    int total_cnt = 0;

    imem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_fault(rsp0_fault),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_fault(rsp1_fault),
        .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;

    // ROM contents: one known instruction word, everything else {addr[15:0], ~addr[15:0]}.
    always_comb begin
        rom_dout = (rom_addr == 32'hBFC00004) ? 32'h00500093
                                              : {rom_addr[15:0], ~rom_addr[15:0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 32'hBFC00000; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_addr = 32'hBFC00008; rsp1_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++;
            if ({req0_ready, req1_ready} !== 2'b00)
                $display("FAIL reset_ready cyc%0d got %b%b want 00", i, req0_ready, req1_ready);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({rsp0_valid, rsp1_valid, rsp0_fault, rsp1_fault} !== 4'b0000)
            $display("FAIL reset_flags got %b%b%b%b want 0000",
                     rsp0_valid, rsp1_valid, rsp0_fault, rsp1_fault);
        else pass_cnt++;
        total_cnt++;
        if (rsp0_data !== 32'h0 || rsp1_data !== 32'h0)
            $display("FAIL reset_data got %h/%h want 0/0", rsp0_data, rsp1_data);
        else pass_cnt++;
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        total_cnt++;
        if (rom_addr !== 32'hBFC00000)
            $display("FAIL idle_rom_addr got %h want bfc00000", rom_addr);
        else pass_cnt++;
    endtask

    task automatic test_single_fetch();
        logic [31:0] addrs[4];
        logic [31:0] words[4];
        addrs = '{32'hBFC00008, 32'hBFC0000C, 32'hBFC00010, 32'hBFC00014};
        words = '{32'h0008FFF7, 32'h000CFFF3, 32'h0010FFEF, 32'h0014FFEB};
        req0_valid = 1'b1; req0_addr = 32'hBFC00004; rsp0_ready = 1'b1;
        #1;
        total_cnt++;
        if (req0_ready !== 1'b1 || rom_addr !== 32'hBFC00004)
            $display("FAIL fetch_grant got rdy=%b addr=%h want 1/bfc00004", req0_ready, rom_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h00500093 || rsp0_fault !== 1'b0)
            $display("FAIL fetch_rsp got v=%b d=%h f=%b want 1/00500093/0",
                     rsp0_valid, rsp0_data, rsp0_fault);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            req0_addr = addrs[i];
            #1;
            total_cnt++;
            if (req0_ready !== 1'b1)
                $display("FAIL stream_ready[%0d] got %b want 1", i, req0_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== words[i] || rsp0_fault !== 1'b0)
                $display("FAIL stream_rsp[%0d] got v=%b d=%h f=%b want 1/%h/0",
                         i, rsp0_valid, rsp0_data, rsp0_fault, words[i]);
            else pass_cnt++;
        end
        req0_valid = 1'b0;
        tick();
        total_cnt++;
        if (rsp0_valid !== 1'b0 || rsp0_data !== 32'h0014FFEB)
            $display("FAIL fetch_drain got v=%b d=%h want 0/0014ffeb", rsp0_valid, rsp0_data);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        int g0 = 0;
        int g1 = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'hBFC00000; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_addr = 32'hBFC00FFC; rsp1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total_cnt++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1))
                $display("FAIL contention_grant[%0d] got %b%b want %b%b",
                         i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
            else pass_cnt++;
            if (req0_ready === 1'b1) g0++;
            if (req1_ready === 1'b1) g1++;
            tick();
        end
        total_cnt++;
        if (g0 != 4 || g1 != 4)
            $display("FAIL contention_share got %0d/%0d want 4/4", g0, g1);
        else pass_cnt++;
        total_cnt++;
        if (rsp1_data !== 32'h0FFCF003 || rsp0_data !== 32'h0000FFFF)
            $display("FAIL contention_data got %h/%h want 0000ffff/0ffcf003", rsp0_data, rsp1_data);
        else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        req1_valid = 1'b1; req1_addr = 32'hBFC00008; rsp1_ready = 1'b0;
        #1;
        total_cnt++;
        if (req1_ready !== 1'b1)
            $display("FAIL bp_first_grant got %b want 1", req1_ready);
        else pass_cnt++;
        tick();
        req1_addr = 32'hBFC0000C;
        req0_valid = 1'b1; req0_addr = 32'hBFC00010; rsp0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
                $display("FAIL bp_grant[%0d] got %b%b want 10", i, req0_ready, req1_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h0008FFF7 || rsp0_data !== 32'h0010FFEF)
                $display("FAIL bp_hold[%0d] got v1=%b d1=%h d0=%h want 1/0008fff7/0010ffef",
                         i, rsp1_valid, rsp1_data, rsp0_data);
            else pass_cnt++;
        end
        rsp1_ready = 1'b1;
        #1;
        total_cnt++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
            $display("FAIL bp_refill_grant got %b%b want 01", req0_ready, req1_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h000CFFF3)
            $display("FAIL bp_refill_rsp got v=%b d=%h want 1/000cfff3", rsp1_valid, rsp1_data);
        else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_faults();
        logic [31:0] addrs[4];
        logic        flts[4];
        logic [31:0] words[4];
        addrs = '{32'hBFBFFFFC, 32'hBFC01000, 32'hBFC00002, 32'hBFC00FFC};
        flts  = '{1'b1, 1'b1, 1'b1, 1'b0};
        words = '{32'h0, 32'h0, 32'h0, 32'h0FFCF003};
        rsp0_ready = 1'b1;
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_addr = addrs[i];
            tick();
            total_cnt++;
            if (rsp0_valid !== 1'b1 || rsp0_fault !== flts[i] || rsp0_data !== words[i])
                $display("FAIL fault[%h] got v=%b f=%b d=%h want 1/%b/%h",
                         addrs[i], rsp0_valid, rsp0_fault, rsp0_data, flts[i], words[i]);
            else pass_cnt++;
        end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_addr = 32'hBFC00008; rsp0_ready = 1'b0;
        req1_valid = 1'b0; rsp1_ready = 1'b1;
        tick();
        rst = 1'b1;
        req0_addr = 32'hBFC0000C;
        req1_valid = 1'b1; req1_addr = 32'hBFC00010;
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b00)
            $display("FAIL midrst_ready got %b%b want 00", req0_ready, req1_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rsp0_valid !== 1'b0 || rsp0_data !== 32'h0 || rsp1_valid !== 1'b0)
            $display("FAIL midrst_rsp got v0=%b d0=%h v1=%b want 0/0/0",
                     rsp0_valid, rsp0_data, rsp1_valid);
        else pass_cnt++;
        rst = 1'b0;
        rsp0_ready = 1'b1;
        #1;
        total_cnt++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL midrst_tie got %b%b want 10", req0_ready, req1_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h000CFFF3)
            $display("FAIL midrst_after got v=%b d=%h want 1/000cfff3", rsp0_valid, rsp0_data);
        else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_back_pressure();
        test_faults();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
